// File: rtl/line_buffer_bank_if.sv
// line_buffer_bank_if
//   Pixel-in / column-out bundle for line_buffer_bank.
//   master : pixel source (drives in_*, observes out_*)
//   slave  : line buffer  (observes in_*, drives out_*)
//   in_valid     pixel strobe, no backpressure
//   in_data      pixel, raster order
//   in_sof       start-of-frame marker (only when LINEBUF_SOF_EN is defined)
//   out_valid    column valid, one cycle after the accepted pixel
//   out_col      NUM_LINES+1 taps, tap k at [k*DATA_W +: DATA_W], k=0 current row
//   out_x        column index of out_col
//   out_rows_ok  every tap holds real image data
interface line_buffer_bank_if #(
    parameter int DATA_W    = 16,
    parameter int LINE_LEN  = 640,
    parameter int NUM_LINES = 2
);
    logic                            in_valid;
    logic [DATA_W-1:0]               in_data;
`ifdef LINEBUF_SOF_EN
    logic                            in_sof;
`endif
    logic                            out_valid;
    logic [(NUM_LINES+1)*DATA_W-1:0] out_col;
    logic [$clog2(LINE_LEN)-1:0]     out_x;
    logic                            out_rows_ok;

`ifdef LINEBUF_SOF_EN
    modport master (output in_valid, in_data, in_sof,
                    input  out_valid, out_col, out_x, out_rows_ok);
    modport slave  (input  in_valid, in_data, in_sof,
                    output out_valid, out_col, out_x, out_rows_ok);
`else
    modport master (output in_valid, in_data,
                    input  out_valid, out_col, out_x, out_rows_ok);
    modport slave  (input  in_valid, in_data,
                    output out_valid, out_col, out_x, out_rows_ok);
`endif
endinterface

// File: rtl/line_buffer_bank.sv
// line_buffer_bank
//   Multi-line buffer for the streaming convolution datapath. Keeps NUM_LINES
//   raster lines in per-line simple dual-port RAMs and emits, for every
//   accepted pixel, a vertical column of NUM_LINES+1 taps at the same x.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset (RAM contents are not cleared)
//     bus    line_buffer_bank_if.slave (pixel in, column out)
//   Optional feature macro: LINEBUF_SOF_EN adds in_sof, which restarts the
//   raster at x=0 of row 0 on the pixel that carries it.
module line_buffer_bank #(
    parameter int DATA_W    = 16,
    parameter int LINE_LEN  = 640,
    parameter int NUM_LINES = 2
) (
    input logic               clk,
    input logic               rst_n,
    line_buffer_bank_if.slave bus
);
    localparam int XW = $clog2(LINE_LEN);
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int FW = $clog2(NUM_LINES + 1);

    logic [XW-1:0]                   col_q, col_d, col_eff;
    logic [XW-1:0]                   x_q, x_d;
    logic [LW-1:0]                   wr_line_q, wr_line_d, wl_eff;
    logic [LW-1:0]                   rd_line_q, rd_line_d;
    logic [FW-1:0]                   row_fill_q, row_fill_d, fill_eff;
    logic [DATA_W-1:0]               pix_q, pix_d;
    logic                            valid_q, valid_d;
    logic                            rows_ok_q, rows_ok_d;
    logic [NUM_LINES-1:0][DATA_W-1:0] rd_q, rd_d;
    logic [LW-1:0]                   tap_line;
    logic [(NUM_LINES+1)*DATA_W-1:0] col_taps;

    // One RAM per line; the read is captured in rd_q in the same edge as the
    // write, so a same-address access returns the pre-write contents.
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        logic [DATA_W-1:0] mem [LINE_LEN];

        always_ff @(posedge clk) begin
            if (bus.in_valid && wl_eff == LW'(l)) begin
                mem[col_eff] <= bus.in_data;
            end
        end

        assign rd_d[l] = bus.in_valid ? mem[col_eff] : rd_q[l];
    end

    always_comb begin
        col_eff  = col_q;
        wl_eff   = wr_line_q;
        fill_eff = row_fill_q;
`ifdef LINEBUF_SOF_EN
        // SOF pixel is written as x=0 of row 0 with an empty fill history.
        if (bus.in_sof) begin
            col_eff  = '0;
            wl_eff   = '0;
            fill_eff = '0;
        end
`endif
        col_d      = col_q;
        wr_line_d  = wr_line_q;
        row_fill_d = row_fill_q;
        pix_d      = pix_q;
        x_d        = x_q;
        rd_line_d  = rd_line_q;
        rows_ok_d  = rows_ok_q;
        valid_d    = bus.in_valid;

        if (bus.in_valid) begin
            pix_d     = bus.in_data;
            x_d       = col_eff;
            rd_line_d = wl_eff;
            rows_ok_d = (fill_eff == FW'(NUM_LINES));
            if (col_eff == XW'(LINE_LEN - 1)) begin
                col_d      = '0;
                wr_line_d  = (wl_eff == LW'(NUM_LINES - 1)) ? '0 : wl_eff + 1'b1;
                row_fill_d = (fill_eff == FW'(NUM_LINES)) ? fill_eff : fill_eff + 1'b1;
            end else begin
                col_d      = col_eff + 1'b1;
                wr_line_d  = wl_eff;
                row_fill_d = fill_eff;
            end
        end
    end

    // Tap k comes from line (rd_line - k) mod NUM_LINES; tap NUM_LINES lands on
    // rd_line itself, i.e. the old data of the line just overwritten.
    always_comb begin
        tap_line = '0;
        col_taps = '0;
        col_taps[DATA_W-1:0] = pix_q;
        for (int k = 1; k <= NUM_LINES; k++) begin
            if (k == NUM_LINES) begin
                tap_line = rd_line_q;
            end else if (rd_line_q >= LW'(k)) begin
                tap_line = rd_line_q - LW'(k);
            end else begin
                tap_line = rd_line_q + LW'(NUM_LINES - k);
            end
            col_taps[k*DATA_W +: DATA_W] = rd_q[tap_line];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            wr_line_q  <= '0;
            row_fill_q <= '0;
            pix_q      <= '0;
            x_q        <= '0;
            rd_line_q  <= '0;
            rows_ok_q  <= 1'b0;
            valid_q    <= 1'b0;
            rd_q       <= '0;
        end else begin
            col_q      <= col_d;
            wr_line_q  <= wr_line_d;
            row_fill_q <= row_fill_d;
            pix_q      <= pix_d;
            x_q        <= x_d;
            rd_line_q  <= rd_line_d;
            rows_ok_q  <= rows_ok_d;
            valid_q    <= valid_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_col     = col_taps;
    assign bus.out_x       = x_q;
    assign bus.out_rows_ok = rows_ok_q;
endmodule

// File: tb/tb_line_buffer_bank.sv
module tb_line_buffer_bank;
    localparam int DW   = 16;
    localparam int L    = 4;
    localparam int N    = 2;
    localparam int XW   = $clog2(L);
    localparam int CW   = (N + 1) * DW;
    localparam int MAXP = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_bank_if #(.DATA_W(DW), .LINE_LEN(L), .NUM_LINES(N)) bus();

    line_buffer_bank #(.DATA_W(DW), .LINE_LEN(L), .NUM_LINES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;

    // Reference model: pixels since reset/SOF kept as a flat raster history.
    // Pixel n sits at x = n % L, row = n / L; tap k is pixel n - k*L.
    int          m_n;
    logic [DW-1:0] hist [MAXP];
    bit          exp_valid;
    int          exp_x;
    bit          exp_ok;
    logic [DW-1:0] exp_tap [N+1];
    bit          exp_known [N+1];

    task automatic m_reset();
        m_n       = 0;
        exp_valid = 1'b0;
        exp_x     = 0;
        exp_ok    = 1'b0;
        for (int k = 0; k <= N; k++) begin
            exp_tap[k]   = '0;
            exp_known[k] = 1'b1;
        end
    endtask

    task automatic m_accept();
        int n_eff;
        int idx;
        n_eff = m_n;
`ifdef LINEBUF_SOF_EN
        if (bus.in_sof) n_eff = 0;
`endif
        if (n_eff < MAXP) hist[n_eff] = bus.in_data;
        exp_x        = n_eff % L;
        exp_ok       = (n_eff / L) >= N;
        exp_tap[0]   = bus.in_data;
        exp_known[0] = 1'b1;
        for (int k = 1; k <= N; k++) begin
            idx = n_eff - k * L;
            if (idx >= 0 && idx < MAXP) begin
                exp_tap[k]   = hist[idx];
                exp_known[k] = 1'b1;
            end else begin
                exp_known[k] = 1'b0;
            end
        end
        m_n       = n_eff + 1;
        exp_valid = 1'b1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else if (bus.in_valid) m_accept();
            else exp_valid = 1'b0;
        end
    end

    task automatic cmp_cycle();
        bit            bad;
        logic [XW-1:0] ex;
        bad = 1'b0;
        ex  = exp_x[XW-1:0];
        if (bus.out_valid !== exp_valid) bad = 1'b1;
        if (bus.out_x !== ex) bad = 1'b1;
        if (bus.out_rows_ok !== exp_ok) bad = 1'b1;
        for (int k = 0; k <= N; k++) begin
            if (exp_known[k] && bus.out_col[k*DW +: DW] !== exp_tap[k]) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            $display("FAIL cycle_cmp t=%0t got valid=%b x=%0d ok=%b col=%h  want valid=%b x=%0d ok=%b taps(2,1,0)=%h,%h,%h known=%b%b%b",
                     $time, bus.out_valid, bus.out_x, bus.out_rows_ok, bus.out_col,
                     exp_valid, ex, exp_ok, exp_tap[2], exp_tap[1], exp_tap[0],
                     exp_known[2], exp_known[1], exp_known[0]);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) cmp_cycle();
        end
    end

    task automatic lit_check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
        else n_pass++;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit s);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
`ifdef LINEBUF_SOF_EN
        bus.in_sof   = s & v;
`else
        if (s) bus.in_data = d;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef LINEBUF_SOF_EN
        bus.in_sof   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Continuous stream 1..20: outputs of pixel p are visible when pixel p+1 is driven.
        for (int p = 1; p <= 20; p++) begin
            drive(1'b1, DW'(p), 1'b0);
            if (p == 9)  lit_check("rows_ok_px8", CW'(bus.out_rows_ok), CW'(0));
            if (p == 10) lit_check("col_px9", bus.out_col, {16'd1, 16'd5, 16'd9});
            if (p == 10) lit_check("rows_ok_px9", CW'(bus.out_rows_ok), CW'(1));
            if (p == 18) lit_check("col_px17", bus.out_col, {16'd9, 16'd13, 16'd17});
            if (p == 18) lit_check("x_px17", CW'(bus.out_x), CW'(0));
        end
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);

        // Same stream with in_valid toggling every cycle.
        do_reset();
        for (int p = 1; p <= 12; p++) begin
            drive(1'b1, DW'(p), 1'b0);
            drive(1'b0, DW'($urandom), 1'b0);
            if (p == 9) lit_check("toggle_col_px9", bus.out_col, {16'd1, 16'd5, 16'd9});
        end

        // Reset in the middle of a line, then restart the stream.
        do_reset();
        for (int p = 1; p <= 6; p++) drive(1'b1, DW'(p + 50), 1'b0);
        do_reset();
        lit_check("reset_col_zero", bus.out_col, CW'(0));
        for (int p = 1; p <= 12; p++) begin
            drive(1'b1, DW'(p), 1'b0);
            if (p == 10) lit_check("rst_col_px9", bus.out_col, {16'd1, 16'd5, 16'd9});
        end

        // Randomized traffic with gaps, one reset mid-run, rare SOF if built in.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            drive($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 99) == 0);
        end
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
